mux_arbiter: RTL and testbench

//   Round-robin arbiter that shares the 2:1 gate-level mux (and the board

---
 rtl/mux_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-way round-robin arbiter for the shared 2:1 output mux.
// Grants A or B with a minimum/maximum tenure and inserts a dead gap between
// owners so the mux output never switches directly from one source to the other.
module mux_arbiter #(
    parameter int MIN_HOLD  = 10,
    parameter int MAX_HOLD  = 100,
    parameter int GAP_TICKS = 5
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       sel,
    output logic       out_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_HOLD);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

    // Gap counter runs 0..GAP_TICKS-1; kept at least one bit wide for GAP_TICKS<=1.
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_cnt_next;
    logic            ptr;
    logic            ptr_next;

    logic [1:0]      grant_next;
    logic            sel_next;
    logic            busy_next;

    // State register with tenure counter, gap counter and round-robin pointer.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            ptr     <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            gap_cnt <= gap_cnt_next;
            ptr     <= ptr_next;
        end
    end

    // Next-state logic: arbitration in IDLE, tenure rules while granted, timed gap.
    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        gap_cnt_next = gap_cnt;
        ptr_next     = ptr;
        case (state)
            IDLE: begin
                cnt_next     = '0;
                gap_cnt_next = '0;
                if (req == 2'b01 || (req == 2'b11 && !ptr)) begin
                    next_state = GRANT_A;
                    cnt_next   = CW'(1);
                end else if (req == 2'b10 || (req == 2'b11 && ptr)) begin
                    next_state = GRANT_B;
                    cnt_next   = CW'(1);
                end
            end
            GRANT_A: begin
                if ((!req[0] && cnt >= MIN_C) || (cnt >= MAX_C && req[1])) begin
                    next_state   = (GAP_TICKS > 0) ? GAP : IDLE;
                    ptr_next     = 1'b1;
                    cnt_next     = '0;
                    gap_cnt_next = '0;
                end else if (cnt < MAX_C) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            GRANT_B: begin
                if ((!req[1] && cnt >= MIN_C) || (cnt >= MAX_C && req[0])) begin
                    next_state   = (GAP_TICKS > 0) ? GAP : IDLE;
                    ptr_next     = 1'b0;
                    cnt_next     = '0;
                    gap_cnt_next = '0;
                end else if (cnt < MAX_C) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state; sel only moves when a grant is entered.
    always_comb begin
        grant_next = 2'b00;
        sel_next   = sel;
        busy_next  = (next_state != IDLE);
        case (next_state)
            GRANT_A: begin
                grant_next = 2'b01;
                sel_next   = 1'b0;
            end
            GRANT_B: begin
                grant_next = 2'b10;
                sel_next   = 1'b1;
            end
            default: begin
                grant_next = 2'b00;
            end
        endcase
    end

    // Output register so every output is a clean flop, aligned with the state.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            grant  <= 2'b00;
            sel    <= 1'b0;
            out_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            grant  <= grant_next;
            sel    <= sel_next;
            out_en <= |grant_next;
            busy   <= busy_next;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed self-checking bench for mux_arbiter
// (MIN_HOLD=4, MAX_HOLD=16, GAP_TICKS=2, plus a GAP_TICKS=0 instance).
module tb_mux_arbiter;

    logic       hz100;
    logic       reset;
    logic [1:0] req;
    logic [1:0] grant;
    logic       sel;
    logic       out_en;
    logic       busy;

    logic [1:0] req0;
    logic [1:0] grant0;
    logic       sel0;
    logic       out_en0;
    logic       busy0;

    int total;
    int bad;

    mux_arbiter #(.MIN_HOLD(4), .MAX_HOLD(16), .GAP_TICKS(2)) dut (
        .hz100  (hz100),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .sel    (sel),
        .out_en (out_en),
        .busy   (busy)
    );

    mux_arbiter #(.MIN_HOLD(4), .MAX_HOLD(16), .GAP_TICKS(0)) dut0 (
        .hz100  (hz100),
        .reset  (reset),
        .req    (req0),
        .grant  (grant0),
        .sel    (sel0),
        .out_en (out_en0),
        .busy   (busy0)
    );

    // 10-unit clock period
    initial begin
        hz100 = 1'b0;
        forever #5 hz100 = ~hz100;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Step one clock and land 1 unit after the rising edge.
    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic [1:0] g, input logic s, input logic b);
        checkOutput({tag, " grant"},  32'(grant),  32'(g));
        checkOutput({tag, " sel"},    32'(sel),    32'(s));
        checkOutput({tag, " out_en"}, 32'(out_en), 32'(|g));
        checkOutput({tag, " busy"},   32'(busy),   32'(b));
    endtask

    task automatic checkZero(input string tag, input logic [1:0] g, input logic s, input logic b);
        checkOutput({tag, " grant0"},  32'(grant0),  32'(g));
        checkOutput({tag, " sel0"},    32'(sel0),    32'(s));
        checkOutput({tag, " out_en0"}, 32'(out_en0), 32'(|g));
        checkOutput({tag, " busy0"},   32'(busy0),   32'(b));
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic applyStimulus();
        logic [1:0] g;
        logic       s;
        logic       b;

        // Reset state
        reset = 1'b1;
        req   = 2'b00;
        req0  = 2'b00;
        #2 reset = 1'b0;
        #1;
        checkMain("reset", 2'b00, 1'b0, 1'b0);
        checkZero("reset", 2'b00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

        // No requests: stays idle
        tick(); tick();
        checkMain("idle", 2'b00, 1'b0, 1'b0);

        // Test 1: async reset mid GRANT_B, then ptr back to A
        req = 2'b10;
        tick();
        checkMain("t1 enterB", 2'b10, 1'b1, 1'b1);
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        checkMain("t1 async", 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        req = 2'b11;
        tick();
        checkMain("t1 ptrA", 2'b01, 1'b0, 1'b1);
        req = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        checkMain("t1 settle", 2'b00, 1'b0, 1'b0);

        // Test 2: one-cycle request still held for MIN_HOLD, then gap, then idle
        req = 2'b01;
        tick();
        checkMain("t2 c1", 2'b01, 1'b0, 1'b1);
        req = 2'b00;
        for (int i = 2; i <= 7; i++) begin
            tick();
            if (i <= 4)      checkMain($sformatf("t2 c%0d", i), 2'b01, 1'b0, 1'b1);
            else if (i <= 6) checkMain($sformatf("t2 c%0d", i), 2'b00, 1'b0, 1'b1);
            else             checkMain($sformatf("t2 c%0d", i), 2'b00, 1'b0, 1'b0);
        end

        // Test 3: both requesting, MAX_HOLD rotation with gaps
        pulseReset();
        req = 2'b11;
        for (int i = 1; i <= 39; i++) begin
            tick();
            if (i <= 16)      begin g = 2'b01; s = 1'b0; b = 1'b1; end
            else if (i <= 18) begin g = 2'b00; s = 1'b0; b = 1'b1; end
            else if (i == 19) begin g = 2'b00; s = 1'b0; b = 1'b0; end
            else if (i <= 35) begin g = 2'b10; s = 1'b1; b = 1'b1; end
            else if (i <= 37) begin g = 2'b00; s = 1'b1; b = 1'b1; end
            else if (i == 38) begin g = 2'b00; s = 1'b1; b = 1'b0; end
            else              begin g = 2'b01; s = 1'b0; b = 1'b1; end
            checkMain($sformatf("t3 c%0d", i), g, s, b);
        end

        // Test 4: lone requester is never pre-empted, counter saturates
        req = 2'b00;
        pulseReset();
        req = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checkMain($sformatf("t4 c%0d", i), 2'b01, 1'b0, 1'b1);
            if (i == 1 || i == 15 || i == 16 || i == 17 || i == 40)
                checkOutput($sformatf("t4 cnt c%0d", i), 32'(dut.cnt), (i < 16) ? i : 16);
        end

        // Test 5: B arrives at cycle 3, A drops at cycle 6
        req = 2'b00;
        pulseReset();
        req = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 2) req = 2'b11;
            if (i == 6) req = 2'b10;
            if (i <= 6)      begin g = 2'b01; s = 1'b0; b = 1'b1; end
            else if (i <= 8) begin g = 2'b00; s = 1'b0; b = 1'b1; end
            else if (i == 9) begin g = 2'b00; s = 1'b0; b = 1'b0; end
            else             begin g = 2'b10; s = 1'b1; b = 1'b1; end
            checkMain($sformatf("t5 c%0d", i), g, s, b);
        end

        // Test 6: no-gap build hands over through a single idle cycle
        req = 2'b00;
        pulseReset();
        req0 = 2'b11;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i <= 16)      begin g = 2'b01; s = 1'b0; b = 1'b1; end
            else if (i == 17) begin g = 2'b00; s = 1'b0; b = 1'b0; end
            else              begin g = 2'b10; s = 1'b1; b = 1'b1; end
            checkZero($sformatf("t6 c%0d", i), g, s, b);
        end
        req0 = 2'b00;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
